// File: rtl/sub_serial_s_if.sv
// Handshake and operand bundle for the bit-serial subtractor sub_serial_s.
// The op port exists only when SUB_SERIAL_ADDSUB_EN is defined.
interface sub_serial_s_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef SUB_SERIAL_ADDSUB_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             overflow;

    modport master (
`ifdef SUB_SERIAL_ADDSUB_EN
        output op,
`endif
        output start, a, b, bin,
        input  busy, done, d, bout, overflow
    );

    modport slave (
`ifdef SUB_SERIAL_ADDSUB_EN
        input  op,
`endif
        input  start, a, b, bin,
        output busy, done, d, bout, overflow
    );
endinterface

// File: rtl/sub_serial_s.sv
// Bit-serial signed subtractor d = a - b - bin, LSB first, one bit per clock.
// Define SUB_SERIAL_ADDSUB_EN to add an op input selecting a + b + bin instead.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// RUN    | processing one bit per cycle, counter = bit index
// DONE   | one-cycle done pulse; start here chains the next op
module sub_serial_s #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_serial_s_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] d_q,      d_d;
    logic             bout_q,   bout_d;
    logic             ovf_q,    ovf_d;
`ifdef SUB_SERIAL_ADDSUB_EN
    logic             op_q,     op_d;
`endif

    logic a_bit, b_bit, diff_bit, br_next, ovf_bit;

    always_comb begin
        a_bit    = a_sh_q[0];
        b_bit    = b_sh_q[0];
        diff_bit = a_bit ^ b_bit ^ br_q;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        ovf_bit  = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`ifdef SUB_SERIAL_ADDSUB_EN
        // br_q doubles as the carry when adding
        if (op_q) begin
            br_next = (a_bit & b_bit) | (a_bit & br_q) | (b_bit & br_q);
            ovf_bit = (a_msb_q == b_msb_q) && (diff_bit != a_msb_q);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
`ifdef SUB_SERIAL_ADDSUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    res_d   = '0;
                    br_d    = bus.bin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`ifdef SUB_SERIAL_ADDSUB_EN
                    op_d    = bus.op;
`endif
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {diff_bit, res_q[WIDTH-1:1]};
                br_d   = br_next;
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish outputs together with the transition to DONE
                    state_d = S_DONE;
                    cnt_d   = '0;
                    d_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    ovf_d   = ovf_bit;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SUB_SERIAL_ADDSUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
`ifdef SUB_SERIAL_ADDSUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.d        = d_q;
    assign bus.bout     = bout_q;
    assign bus.overflow = ovf_q;
endmodule
